// File: rtl/uart8_rx_buffer.sv
// Byte FIFO behind an 8-bit UART receiver: edge-detects the receiver's done strobe,
// stores one byte per frame, presents the head byte first-word-fall-through.
module uart8_rx_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic          rx_err,
  input  logic [7:0]    rx_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    err_count,
  input  logic          clr_status
);

  // Write/read counters carry one extra wrap bit so count = writes - reads
  // distinguishes full from empty; the low AW bits are the pointers.
  logic          done_q, err_q;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push_ev, err_ev, pop, wr_en, drop;

  assign count     = wr_q - rd_q;
  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem_q[rd_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign err_count = err_cnt_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    push_ev    = rx_done & ~done_q & ~rx_err;
    err_ev     = rx_err & ~err_q;
    pop        = out_valid & out_ready;
    wr_en      = push_ev & (~full | pop);
    drop       = push_ev & full & ~pop;
    wr_d       = wr_q + (AW+1)'(wr_en);
    rd_d       = rd_q + (AW+1)'(pop);
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      err_cnt_d  = '0;
    end
    // Events override a same-cycle clear: a cleared counter restarts at 1.
    if (drop) overflow_d = 1'b1;
    if (err_ev && err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // Edge detectors start high: a level already present at release is not an edge.
      done_q     <= 1'b1;
      err_q      <= 1'b1;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      done_q     <= rx_done;
      err_q      <= rx_err;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the counters, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: doc/uart8_rx_buffer.md
UART8_RX_BUFFER -- requirements
Module: uart8_rx_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 16, FIFO entries (power of two, 2..256); AW = log2(DEPTH).
REQ-002 The block SHALL have port: clk  in  1  16x-oversample rx clock, same clock that drives the 8-bit receiver.
REQ-003 The block SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: rx_done  in  1  receiver done strobe (high 1..16 ticks per byte).
REQ-005 The block SHALL have port: rx_err  in  1  receiver error flag.
REQ-006 The block SHALL have port: rx_data  in  8  receiver parallel data, valid while rx_done high.
REQ-007 The block SHALL have port: out_ready  in  1  consumer accepts head byte.
REQ-008 The block SHALL have port: out_valid  out  1  FIFO non-empty, head byte presented.
REQ-009 The block SHALL have port: out_data  out  8  head byte (first-word-fall-through).
REQ-010 The block SHALL have port: count  out  AW+1  number of stored bytes, 0..DEPTH.
REQ-011 The block SHALL have port: full  out  1  count == DEPTH.
REQ-012 The block SHALL have port: overflow  out  1  sticky: a byte was dropped.
REQ-013 The block SHALL have port: err_count  out  8  saturating count of receive errors.
REQ-014 The block SHALL have port: clr_status  in  1  synchronous clear of overflow and err_count.

Function
REQ-015 Capture: a register done_q SHALL hold the previous-cycle rx_done; a push event SHALL occur on a clock edge where rx_done=1, done_q=0 and rx_err=0.
REQ-016 Each receiver byte SHALL produce exactly one push, however many ticks rx_done stays high.
REQ-017 Error event: a register err_q SHALL hold the previous-cycle rx_err; each rising edge of rx_err (rx_err=1, err_q=0) SHALL increment err_count by 1, saturating at 255.
REQ-018 A push coincident with rx_err=1 SHALL be suppressed (no write) and only the error event SHALL be counted.
REQ-019 Push latency: the byte written at edge k SHALL be visible on out_data, with out_valid=1, immediately after edge k when the FIFO was empty.
REQ-020 Pop: a pop SHALL occur on an edge where out_valid=1 and out_ready=1; the read pointer SHALL advance by 1 and out_data SHALL show the next entry after that edge.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 out_data SHALL be a function of the storage and read pointer only; it SHALL NOT change while out_valid=1 and no pop occurs.
REQ-023 Pointers SHALL be AW bits and wrap modulo DEPTH; count SHALL be AW+1 bits, computed as writes minus reads.
REQ-024 Push and pop in the same cycle (FIFO non-empty) SHALL both take effect, with count unchanged.
REQ-025 Push when full with a simultaneous pop SHALL be accepted, with no overflow.
REQ-026 Push when full without a pop SHALL discard the byte, set overflow=1 and leave storage, pointers and count unchanged.
REQ-027 Push when empty with out_ready=1 SHALL write the byte and SHALL NOT pop it in the same cycle.
REQ-028 clr_status=1 SHALL clear overflow and err_count at the next edge; an overflow or error event in the same cycle SHALL take priority (overflow=1, err_count=1).
REQ-029 The block SHALL have no FSM beyond the edge detectors; the FIFO storage SHALL be a register array without reset.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force: pointers=0, count=0, out_valid=0, full=0, overflow=0, err_count=0, done_q=1, err_q=1.
REQ-031 Reset values of 1 for done_q and err_q SHALL prevent a push or error count from an rx_done or rx_err level already present at reset release.
REQ-032 Reset mid-operation SHALL discard all stored bytes; out_data SHALL be don't-care while out_valid=0.

Verification
REQ-033 The bench SHALL verify: single byte — rx_done high 16 ticks, rx_data=0xA5, out_ready=0 -> exactly one entry, count=1, out_valid=1, out_data=0xA5 from the edge after the rising edge.
REQ-034 The bench SHALL verify: ordering/wrap — DEPTH=16, push 0x00..0x13 interleaved with pops, never exceeding 16 stored -> pops return 0x00..0x13 in order, pointers wrap, overflow=0.
REQ-035 The bench SHALL verify: overflow — push 17 bytes with out_ready=0 -> full=1, count=16, overflow=1, 16 pops return bytes 1..16, and byte 17 is lost.
REQ-036 The bench SHALL verify: full simultaneous push and pop — at count=16, push 0x5A with out_ready=1 -> count stays 16, overflow=0, and 0x5A is eventually read last.
REQ-037 The bench SHALL verify: errors — 3 rx_err pulses, one of them coincident with rx_done and data 0x77 -> err_count=3, 0x77 not stored; 300 pulses -> err_count=255; clr_status -> err_count=0.
REQ-038 The bench SHALL verify: reset — reset with rx_done held high across release and 5 bytes stored -> count=0, out_valid=0, and no push until rx_done falls and rises again.
